// File: rtl/axi_mem_slv_s.sv
// AXI4 slave memory terminating the NoC master port.
// INCR full-width bursts into a word array; DECERR outside the window.
module axi_mem_slv_s #(
    parameter int                DATA_W    = 128,
    parameter int                ADDR_W    = 64,
    parameter int                MEM_DEPTH = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                awvalid,
    output logic                awready,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [7:0]          awlen,
    input  logic                wvalid,
    output logic                wready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    output logic                bvalid,
    input  logic                bready,
    output logic [1:0]          bresp,
    input  logic                arvalid,
    output logic                arready,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [7:0]          arlen,
    output logic                rvalid,
    input  logic                rready,
    output logic [DATA_W-1:0]   rdata,
    output logic                rlast,
    output logic [1:0]          rresp
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wstate_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_t;

    function automatic logic [IDX_W-1:0] to_idx(
        input logic [ADDR_W-1:0] a
    );
        return IDX_W'((a - BASE_ADDR) >> OFF_W);
    endfunction

    // Whole burst must fit; widened by one bit so idx+len cannot overflow.
    function automatic logic in_range(
        input logic [ADDR_W-1:0] a,
        input logic [7:0]        l
    );
        return (a >= BASE_ADDR) &&
               (({1'b0, (a - BASE_ADDR) >> OFF_W}
                 + (ADDR_W+1)'(l))
                < (ADDR_W+1)'(MEM_DEPTH));
    endfunction

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    wstate_t    wst, wst_n;
    rstate_t    rst, rst_n;
    logic       live;

    logic [IDX_W-1:0] widx;
    logic [7:0]       wlen;
    logic [7:0]       wcnt;
    logic             wrng;
    logic             werr;

    logic [IDX_W-1:0] ridx;
    logic [7:0]       rlen;
    logic [7:0]       rcnt;
    logic             rrng;

    logic aw_hs, w_hs, ar_hs, r_hs;
    logic w_end, wl_err;
    logic [IDX_W-1:0] waddr;
    logic [IDX_W-1:0] ar_idx;
    logic [IDX_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_word;
    logic             ar_rng;

    assign aw_hs  = awvalid && awready;
    assign w_hs   = wvalid && wready;
    assign ar_hs  = arvalid && arready;
    assign r_hs   = rvalid && rready;
    assign w_end  = (wcnt == wlen);
    assign wl_err = (wlast != w_end);
    assign waddr  = widx + IDX_W'(wcnt);
    assign ar_idx = to_idx(araddr);
    assign ar_rng = in_range(araddr, arlen);

    // Prefetch: next beat is fetched on the handshake of the current one.
    assign rd_addr = ar_hs ? ar_idx
                           : ridx + IDX_W'(rcnt) + IDX_W'(1);
    assign rd_word = mem[rd_addr];

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wst  <= W_IDLE;
            rst  <= R_IDLE;
            live <= 1'b0;
        end else begin
            wst  <= wst_n;
            rst  <= rst_n;
            live <= 1'b1;
        end
    end

    always_comb begin
        wst_n   = wst;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        unique case (wst)
            W_IDLE: begin
                awready = live;
                if (awvalid && live)
                    wst_n = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid && w_end)
                    wst_n = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready)
                    wst_n = W_IDLE;
            end
            default: wst_n = W_IDLE;
        endcase
    end

    always_comb begin
        rst_n   = rst;
        arready = 1'b0;
        rvalid  = 1'b0;
        unique case (rst)
            R_IDLE: begin
                arready = live;
                if (arvalid && live)
                    rst_n = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                if (rready && rlast)
                    rst_n = R_IDLE;
            end
            default: rst_n = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            widx  <= '0;
            wlen  <= '0;
            wcnt  <= '0;
            wrng  <= 1'b0;
            werr  <= 1'b0;
            bresp <= 2'b00;
        end else begin
            if (aw_hs) begin
                widx <= to_idx(awaddr);
                wlen <= awlen;
                wrng <= in_range(awaddr, awlen);
                wcnt <= '0;
                werr <= 1'b0;
            end
            if (w_hs) begin
                wcnt <= wcnt + 8'd1;
                if (wl_err)
                    werr <= 1'b1;
                if (w_end) begin
                    if (!wrng)
                        bresp <= 2'b11;
                    else if (werr || wl_err)
                        bresp <= 2'b10;
                    else
                        bresp <= 2'b00;
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (aresetn && w_hs && wrng) begin
            for (int b = 0; b < NB; b++)
                if (wstrb[b])
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            ridx  <= '0;
            rlen  <= '0;
            rcnt  <= '0;
            rrng  <= 1'b0;
            rdata <= '0;
            rlast <= 1'b0;
            rresp <= 2'b00;
        end else if (ar_hs) begin
            ridx  <= ar_idx;
            rlen  <= arlen;
            rrng  <= ar_rng;
            rcnt  <= '0;
            rdata <= ar_rng ? rd_word : '0;
            rlast <= (arlen == 8'd0);
            rresp <= ar_rng ? 2'b00 : 2'b11;
        end else if (r_hs) begin
            if (rlast) begin
                rlast <= 1'b0;
            end else begin
                rcnt  <= rcnt + 8'd1;
                rdata <= rrng ? rd_word : '0;
                rlast <= ((rcnt + 8'd1) == rlen);
            end
        end
    end

endmodule
